// File: rtl/ram_sdp_ctrl.sv
// ram_sdp_ctrl: simple-dual-port RAM with byte-enable writes, read-during-write select,
// optional output register and a whole-array clear FSM that stalls accesses while busy.
module ram_sdp_ctrl #(
   parameter int                DATA_W   = 16,
   parameter int                ADDR_W   = 9,
   parameter logic [DATA_W-1:0] INIT_VAL = 'hFF,
   parameter bit                RDW_MODE = 1'b0,
   parameter bit                OUT_REG  = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [DATA_W/8-1:0] wbe,
   input  logic [ADDR_W-1:0]   w_addr,
   input  logic [DATA_W-1:0]   data_in,
   input  logic                re,
   input  logic [ADDR_W-1:0]   r_addr,
   input  logic                clr_req,
   output logic [DATA_W-1:0]   data_out,
   output logic                rd_valid,
   output logic                init_busy
);
   localparam int NB    = DATA_W / 8;
   localparam int DEPTH = 2 ** ADDR_W;
   typedef enum logic {CLEAR, RUN} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_en, rd_en;
   logic [DATA_W-1:0] old_w, new_w, rd_data;
   logic [DATA_W-1:0] d1_q, d2_q;
   logic              v1_q, v2_q;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end
   // The pointer wraps to zero on its own after the last word, ready for the next clear.
   always_comb begin
      state_d   = (state_q == RUN) ? (clr_req ? CLEAR : RUN) : (&clr_ptr_q ? RUN : CLEAR);
      clr_ptr_d = (state_q == RUN) ? '0 : clr_ptr_q + 1'b1;
   end
   always_comb begin
      init_busy = (state_q == CLEAR);
      wr_en     = !init_busy && we;
      rd_en     = !init_busy && re;
   end
   always_comb begin
      old_w = mem[r_addr];
      new_w = old_w;
      for (int i = 0; i < NB; i++)
         if (wbe[i]) new_w[8*i +: 8] = data_in[8*i +: 8];
      rd_data = (RDW_MODE && wr_en && (w_addr == r_addr)) ? new_w : old_w;
   end
   always_ff @(posedge clk) begin
      if (init_busy) mem[clr_ptr_q] <= INIT_VAL;
      else if (wr_en)
         for (int i = 0; i < NB; i++)
            if (wbe[i]) mem[w_addr][8*i +: 8] <= data_in[8*i +: 8];
   end
   // Data registers only load on a valid read so data_out holds between reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         d1_q <= INIT_VAL;
         d2_q <= INIT_VAL;
      end else begin
         v1_q <= rd_en;
         v2_q <= v1_q;
         if (rd_en) d1_q <= rd_data;
         if (v1_q) d2_q <= d1_q;
      end
   end
   assign data_out = OUT_REG ? d2_q : d1_q;
   assign rd_valid = OUT_REG ? v2_q : v1_q;
endmodule

// File: tb/tb_ram_sdp_ctrl.sv
// tb_ram_sdp_ctrl: drives two instances (old-data/latency-1 and write-through/latency-2)
// with one directed sequence; a reference array feeds per-instance expected-read queues.
module tb_ram_sdp_ctrl;
   logic        clk = 1'b0, rst = 1'b1, we = 1'b0, re = 1'b0, clr_req = 1'b0;
   logic [1:0]  wbe = '0;
   logic [8:0]  w_addr = '0, r_addr = '0;
   logic [15:0] data_in = '0;
   logic [15:0] do0, do1;
   logic        v0, v1, b0, b1;
   logic [15:0] m [512];
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   ram_sdp_ctrl u0 (
      .clk(clk), .rst(rst), .we(we), .wbe(wbe), .w_addr(w_addr), .data_in(data_in),
      .re(re), .r_addr(r_addr), .clr_req(clr_req),
      .data_out(do0), .rd_valid(v0), .init_busy(b0)
   );
   ram_sdp_ctrl #(.RDW_MODE(1'b1), .OUT_REG(1'b1)) u1 (
      .clk(clk), .rst(rst), .we(we), .wbe(wbe), .w_addr(w_addr), .data_in(data_in),
      .re(re), .r_addr(r_addr), .clr_req(clr_req),
      .data_out(do1), .rd_valid(v1), .init_busy(b1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (v0) begin
         if (q0.size() == 0) chk("u0 unexpected rd_valid", 32'd1, 32'd0);
         else chk("u0 rdata", {16'd0, do0}, {16'd0, q0.pop_front()});
      end
      if (v1) begin
         if (q1.size() == 0) chk("u1 unexpected rd_valid", 32'd1, 32'd0);
         else chk("u1 rdata", {16'd0, do1}, {16'd0, q1.pop_front()});
      end
   end

   task automatic clr_model();
      foreach (m[i]) m[i] = 16'h00FF;
   endtask

   task automatic access(input logic w, input logic [1:0] be, input logic [8:0] wa,
                         input logic [15:0] d, input logic r, input logic [8:0] ra);
      logic [15:0] old, mrg, tmp;
      we = w; wbe = be; w_addr = wa; data_in = d; re = r; r_addr = ra;
      if (r) begin
         old = m[ra];
         mrg = old;
         for (int i = 0; i < 2; i++) if (be[i]) mrg[8*i +: 8] = d[8*i +: 8];
         q0.push_back(old);
         q1.push_back((w && wa == ra) ? mrg : old);
      end
      if (w) begin
         tmp = m[wa];
         for (int i = 0; i < 2; i++) if (be[i]) tmp[8*i +: 8] = d[8*i +: 8];
         m[wa] = tmp;
      end
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0;
   endtask

   task automatic busy_len(input string tag);
      int n = 0;
      while (b0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk(tag, n, 512);
      chk({tag, " u1 idle"}, {31'd0, b1}, 32'd0);
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr();
      clr_req = 1'b1;
      @(posedge clk); #1;
      clr_req = 1'b0;
      clr_model();
   endtask

   initial begin
      clr_model();
      #2 rst = 1'b0;
      #10;
      chk("reset busy", {31'd0, b0}, 32'd1);
      chk("reset valid", {31'd0, v0}, 32'd0);
      chk("reset dout u0", {16'd0, do0}, 32'h00FF);
      chk("reset dout u1", {16'd0, do1}, 32'h00FF);
      #5 rst = 1'b1;
      busy_len("t1 busy cycles");
      for (int a = 0; a < 512; a++) access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'(a));
      drain();
      access(1'b1, 2'b01, 9'd5, 16'hA55A, 1'b0, 9'd0);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd5);
      access(1'b1, 2'b11, 9'd7, 16'h1234, 1'b1, 9'd7);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd7);
      access(1'b1, 2'b10, 9'd9, 16'hABCD, 1'b1, 9'd9);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd9);
      access(1'b1, 2'b11, 9'd10, 16'h5555, 1'b1, 9'd5);
      access(1'b1, 2'b00, 9'd10, 16'hFFFF, 1'b0, 9'd0);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd10);
      drain();
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd0);
      chk("t4 u0 valid e1", {31'd0, v0}, 32'd1);
      chk("t4 u1 valid e1", {31'd0, v1}, 32'd0);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd1);
      chk("t4 u1 valid e2", {31'd0, v1}, 32'd1);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd2);
      chk("t4 u1 valid e3", {31'd0, v1}, 32'd1);
      @(posedge clk); #1;
      chk("t4 u1 valid e4", {31'd0, v1}, 32'd1);
      chk("t4 u0 valid e4", {31'd0, v0}, 32'd0);
      @(posedge clk); #1;
      chk("t4 u1 valid e5", {31'd0, v1}, 32'd0);
      access(1'b1, 2'b11, 9'd3, 16'h1111, 1'b0, 9'd0);
      access(1'b1, 2'b11, 9'd4, 16'h2222, 1'b0, 9'd0);
      drain();
      pulse_clr();
      chk("t5 busy after clr_req", {31'd0, b0}, 32'd1);
      we = 1'b1; wbe = 2'b11; w_addr = 9'd3; data_in = 16'hBEEF; re = 1'b1; r_addr = 9'd4;
      clr_req = 1'b1;
      busy_len("t5 busy cycles");
      we = 1'b0; re = 1'b0; clr_req = 1'b0;
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd3);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd4);
      access(1'b1, 2'b11, 9'd7, 16'h1234, 1'b0, 9'd0);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd7);
      drain();
      chk("t6 dout held u0", {16'd0, do0}, 32'h1234);
      chk("t6 dout held u1", {16'd0, do1}, 32'h1234);
      pulse_clr();
      repeat (100) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("t6 reset busy", {31'd0, b0}, 32'd1);
      chk("t6 reset dout u0", {16'd0, do0}, 32'h00FF);
      chk("t6 reset dout u1", {16'd0, do1}, 32'h00FF);
      chk("t6 reset valid", {31'd0, v1}, 32'd0);
      #2 rst = 1'b1;
      busy_len("t6 busy cycles");
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd7);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd0);
      access(1'b0, 2'b00, 9'd0, 16'd0, 1'b1, 9'd511);
      drain();
      chk("u0 queue drained", q0.size(), 32'd0);
      chk("u1 queue drained", q1.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
